pe_seq: RTL and testbench
=========================

Name: pe_seq

Overview:
Parametrised, registered priority encoder with request capture and a valid/ready output handshake. It is the clocked successor to the team's 8-to-3 combinational encoder with enable. Requests on N input lines are latched into a pending vector. The block then emits the encoded index of the highest-priority pending line, one index per accepted transfer. It sits between interrupt/event sources and a consumer that services one index at a time.

Parameters:
N, 8, number of request lines; must be at least 2.
W, $clog2(N), width of the encoded index; derived localparam, not overridable.
PRIO_HIGH, 1, 1 means the highest index wins (matches the existing encoder); 0 means the lowest index wins.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active-low.
en  input  1  enable; gates request capture and output loading.
i  input  N  request lines, sampled each cycle while en=1.
y  output  W  encoded index of the presented request.
valid  output  1  y holds a request awaiting acceptance.
ready  input  1  consumer accepts y when valid=1 and ready=1.
pending  output  N  registered vector of captured, not-yet-presented requests.
any  output  1  OR of pending and valid.

Behaviour:
- Reset (rst_n=0, async): pending=0, valid=0, y=0, any=0. Reset asserted mid-transfer discards all requests, including the presented one.
- Transfer: a transfer occurs when valid=1 and ready=1 at a rising edge.
- Slot free: the output slot is free when valid=0, or when a transfer occurs in the current cycle.
- Selection: sel is the index of the highest set bit of pending (PRIO_HIGH=1) or the lowest (PRIO_HIGH=0). Selection uses the registered pending value, not the current i.
- Load: when the slot is free, en=1 and pending!=0:
  - y<=sel and valid<=1.
  - Bit sel is cleared from pending at the same edge.
- Drain: when the slot is free and (pending==0 or en=0), valid<=0. y holds its last value.
- Hold: when valid=1 and ready=0, y and valid are held unchanged.
- Capture: pending_next = (pending & ~load_mask) | (en ? i : 0).
  - A capture on bit sel in the load cycle keeps that bit set, so it becomes a new request.
  - Requests on bits already pending merge into one; this is not an error.
- Latency: i asserted at edge t sets pending at t+1. With an empty slot, valid=1 and y=index follow at t+2. Back-to-back accepted transfers give one index per cycle.
- en=0: no capture and no new load. A held output can still be accepted. pending is frozen.
- A held request matching the current y may be re-requested; it is presented again after acceptance.
- any is combinational from registers: |pending | valid.

Optional Feature:
Macro PE_SEQ_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt [7:0]. Reset value is 0.
  - At each edge with en=1, drop_cnt increments by the popcount of (i & pending & ~load_mask), i.e. requests merged into already-pending bits.
  - drop_cnt saturates at 255.
  - Adds input drop_clr [1]; drop_clr=1 synchronously zeroes the count and takes priority over increment.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
1. N=8, PRIO_HIGH=1, ready=1, en=1. Pulse i=8'b1010_0100 for 1 cycle -> two cycles later, y sequence is 7, 5, 2 on consecutive cycles with valid=1, then valid=0 and any=0.
2. PRIO_HIGH=0, same pulse -> y sequence is 2, 5, 7.
3. ready=0 with i=8'h81 captured -> y=7 and valid=1 held stable for 5 cycles with pending=8'h01. Then ready=1 gives y=0 next, then valid=0.
4. en=0 while i=8'hFF for 3 cycles -> pending stays 0 and valid stays 0. Then en=1 with i=0 -> no output.
5. Assert rst_n=0 asynchronously (mid-cycle) while valid=1 and pending=8'h0F -> valid, y, pending and any are all 0 immediately, before the next clock edge.
6. With PE_SEQ_DROP_CNT_EN: ready=0, hold i=8'h03 for 4 cycles -> drop_cnt=6 (first cycle captures; the next 3 cycles merge 2 bits each, minus none loaded). Then drop_clr=1 -> drop_cnt=0.

Source files
------------

// File: rtl/pe_seq.sv
// Registered priority encoder with request capture and a valid/ready output slot.
// Optional saturating merged-request counter enabled by defining PE_SEQ_DROP_CNT_EN.
module pe_seq #(
  parameter int unsigned N         = 8,
  parameter bit          PRIO_HIGH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         i,
  output logic [$clog2(N)-1:0] y,
  output logic                 valid,
  input  logic                 ready,
  output logic [N-1:0]         pending,
`ifdef PE_SEQ_DROP_CNT_EN
  output logic [7:0]           drop_cnt,
  input  logic                 drop_clr,
`endif
  output logic                 any
);

  localparam int unsigned W = $clog2(N);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;

  logic         xfer;
  logic         slot_free;
  logic         load;
  logic [W-1:0] sel;
  logic [N-1:0] load_mask;
  logic [N-1:0] capt;

  assign xfer      = valid_q & ready;
  assign slot_free = ~valid_q | xfer;
  assign load      = slot_free & en & (|pending_q);
  assign load_mask = load ? (N'(1) << sel) : '0;
  assign capt      = en ? i : '0;

  // Later iterations overwrite earlier ones, so loop order sets the priority.
  always_comb begin
    sel = '0;
    if (PRIO_HIGH) begin
      for (int k = 0; k < int'(N); k++) begin
        if (pending_q[k]) sel = W'(k);
      end
    end else begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        if (pending_q[k]) sel = W'(k);
      end
    end
  end

  always_comb begin
    pending_d = (pending_q & ~load_mask) | capt;
    y_d       = y_q;
    valid_d   = valid_q;
    if (slot_free) begin
      valid_d = load;
      if (load) y_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
    end
  end

  assign pending = pending_q;
  assign y       = y_q;
  assign valid   = valid_q;
  assign any     = (|pending_q) | valid_q;

`ifdef PE_SEQ_DROP_CNT_EN
  localparam int unsigned PopW = $clog2(N + 1);
  localparam int unsigned SumW = ((PopW > 8) ? PopW : 8) + 1;

  logic [N-1:0]    merged;
  logic [PopW-1:0] pop;
  logic [SumW-1:0] cnt_sum;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  // Requests landing on bits that stay pending collapse into the existing one.
  assign merged = capt & pending_q & ~load_mask;

  always_comb begin
    pop = '0;
    for (int k = 0; k < int'(N); k++) begin
      pop = pop + PopW'(merged[k]);
    end
  end

  assign cnt_sum = SumW'(drop_cnt_q) + SumW'(pop);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (en) begin
      drop_cnt_d = (cnt_sum > SumW'(255)) ? 8'hFF : cnt_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pe_seq.sv
// Directed bench for pe_seq: one high-priority and one low-priority instance share stimulus.
module tb_pe_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       ready;
  logic [7:0] i;

  logic [2:0] y_h, y_l;
  logic       valid_h, valid_l;
  logic [7:0] pending_h, pending_l;
  logic       any_h, any_l;
`ifdef PE_SEQ_DROP_CNT_EN
  logic [7:0] drop_cnt_h, drop_cnt_l;
  logic       drop_clr;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  pe_seq #(.N(8), .PRIO_HIGH(1'b1)) dut_hi (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i       (i),
    .y       (y_h),
    .valid   (valid_h),
    .ready   (ready),
    .pending (pending_h),
`ifdef PE_SEQ_DROP_CNT_EN
    .drop_cnt(drop_cnt_h),
    .drop_clr(drop_clr),
`endif
    .any     (any_h)
  );

  pe_seq #(.N(8), .PRIO_HIGH(1'b0)) dut_lo (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i       (i),
    .y       (y_l),
    .valid   (valid_l),
    .ready   (ready),
    .pending (pending_l),
`ifdef PE_SEQ_DROP_CNT_EN
    .drop_cnt(drop_cnt_l),
    .drop_clr(drop_clr),
`endif
    .any     (any_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    ready = 1'b0;
    i     = 8'h00;
`ifdef PE_SEQ_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_valid", 32'(valid_h), 32'd0);
    chk("rst_y", 32'(y_h), 32'd0);
    chk("rst_pending", 32'(pending_h), 32'd0);
    chk("rst_any", 32'(any_h), 32'd0);
    rst_n = 1'b1;

    // Burst A4: high order 7,5,2 and low order 2,5,7
    en = 1'b1; ready = 1'b1;
    tick();
    i = 8'hA4;
    tick();
    chk("t1_capture_pending", 32'(pending_h), 32'hA4);
    chk("t1_capture_valid", 32'(valid_h), 32'd0);
    i = 8'h00;
    tick();
    chk("t1_y0", 32'(y_h), 32'd7);
    chk("t1_v0", 32'(valid_h), 32'd1);
    chk("t1_pend0", 32'(pending_h), 32'h24);
    chk("t2_y0", 32'(y_l), 32'd2);
    chk("t2_pend0", 32'(pending_l), 32'hA0);
    tick();
    chk("t1_y1", 32'(y_h), 32'd5);
    chk("t2_y1", 32'(y_l), 32'd5);
    tick();
    chk("t1_y2", 32'(y_h), 32'd2);
    chk("t1_v2", 32'(valid_h), 32'd1);
    chk("t2_y2", 32'(y_l), 32'd7);
    chk("t1_pend2", 32'(pending_h), 32'h00);
    tick();
    chk("t1_drain_valid", 32'(valid_h), 32'd0);
    chk("t1_drain_any", 32'(any_h), 32'd0);
    chk("t1_drain_yhold", 32'(y_h), 32'd2);
    chk("t2_drain_valid", 32'(valid_l), 32'd0);

    // Back-pressure hold with 81
    ready = 1'b0;
    i = 8'h81;
    tick();
    chk("t3_capture", 32'(pending_h), 32'h81);
    i = 8'h00;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_y", 32'(y_h), 32'd7);
      chk("t3_hold_valid", 32'(valid_h), 32'd1);
      chk("t3_hold_pending", 32'(pending_h), 32'h01);
      tick();
    end
    ready = 1'b1;
    tick();
    chk("t3_next_y", 32'(y_h), 32'd0);
    chk("t3_next_valid", 32'(valid_h), 32'd1);
    chk("t3_next_pending", 32'(pending_h), 32'h00);
    tick();
    chk("t3_end_valid", 32'(valid_h), 32'd0);
    chk("t3_end_any", 32'(any_h), 32'd0);

    // en=0 blocks capture
    en = 1'b0;
    i = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_pending", 32'(pending_h), 32'h00);
      chk("t4_valid", 32'(valid_h), 32'd0);
    end
    en = 1'b1;
    i = 8'h00;
    tick();
    tick();
    chk("t4_idle_valid", 32'(valid_h), 32'd0);
    chk("t4_idle_any", 32'(any_h), 32'd0);

    // en=0: held output still accepted, pending frozen, no new load
    ready = 1'b0;
    i = 8'hC0;
    tick();
    i = 8'h00;
    tick();
    chk("en0_pre_y", 32'(y_h), 32'd7);
    chk("en0_pre_pending", 32'(pending_h), 32'h40);
    en = 1'b0;
    ready = 1'b1;
    tick();
    chk("en0_accept_valid", 32'(valid_h), 32'd0);
    chk("en0_frozen", 32'(pending_h), 32'h40);
    chk("en0_any", 32'(any_h), 32'd1);
    en = 1'b1;
    tick();
    chk("en1_y", 32'(y_h), 32'd6);
    chk("en1_valid", 32'(valid_h), 32'd1);
    tick();
    chk("en1_drain", 32'(valid_h), 32'd0);

    // Async reset mid-cycle with valid=1 and pending=0F
    ready = 1'b0;
    i = 8'h0F;
    tick();
    tick();
    i = 8'h00;
    chk("t5_pre_valid", 32'(valid_h), 32'd1);
    chk("t5_pre_y", 32'(y_h), 32'd3);
    chk("t5_pre_pending", 32'(pending_h), 32'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(valid_h), 32'd0);
    chk("t5_y", 32'(y_h), 32'd0);
    chk("t5_pending", 32'(pending_h), 32'h00);
    chk("t5_any", 32'(any_h), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef PE_SEQ_DROP_CNT_EN
    // Occupy the slot first so no load masks the merged bits
    en = 1'b1;
    ready = 1'b0;
    i = 8'h80;
    tick();
    i = 8'h00;
    tick();
    chk("t6_slot_busy", 32'(valid_h), 32'd1);
    i = 8'h03;
    tick();
    chk("t6_first", 32'(drop_cnt_h), 32'd0);
    tick();
    tick();
    tick();
    chk("t6_cnt", 32'(drop_cnt_h), 32'd6);
    i = 8'h00;
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("t6_clr", 32'(drop_cnt_h), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
